// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive datapath.
//   rx_state_t       - 3-bit receive datapath state encoding
//   DEF_CLKS_PER_BIT - default clk cycles per UART bit period
//   DEF_DATA_BITS    - default data bits per frame
//   PARITY_ODD       - parity polarity (0 = even parity)
// Optional feature macro used by the datapath: UART_RX_PARITY_EN.
package uart_pkg;

    localparam int unsigned DEF_CLKS_PER_BIT = 16;
    localparam int unsigned DEF_DATA_BITS    = 8;

    // Expected parity bit = XOR(data) ^ PARITY_ODD.
    localparam logic PARITY_ODD = 1'b0;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_ARMED     = 3'd1,
        RX_START_CHK = 3'd2,
        RX_DATA      = 3'd3,
        RX_PARITY    = 3'd4,
        RX_STOP      = 3'd5,
        RX_DONE      = 3'd6
    } rx_state_t;

endpackage

// File: rtl/rx_sync_edge.sv
// rx_sync_edge: brings the raw serial line into the clk domain and flags
// falling edges of the synchronised line.
//   i_clk   - system clock
//   i_reset - asynchronous active-high reset (all flops set to 1 = idle line)
//   i_rx    - raw serial line, asynchronous to i_clk
//   o_rx_s  - synchronised line
//   o_fall  - high while synced line is 0 and its delayed copy is 1
module rx_sync_edge
    import uart_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_sync_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_sync_q <= 1'b1;
        end else begin
            r_meta   <= i_rx;
            r_sync   <= r_meta;
            r_sync_q <= r_sync;
        end
    end

    assign o_rx_s = r_sync;
    assign o_fall = r_sync_q & ~r_sync;

endmodule

// File: rtl/uart_rx_datapath.sv
// uart_rx_datapath: UART serial receive datapath. Detects a start edge,
// waits for the controller's rx_start, times bit centres, deserialises
// LSB-first and checks the stop bit (and even parity when compiled in).
//   clk            - system clock
//   reset          - asynchronous active-high reset
//   rx_in          - raw serial line, idle high
//   rx_start       - controller ack of start_detected; launches reception
//   start_detected - one-cycle pulse on a falling edge while idle
//   rx_done        - one-cycle pulse when a frame finishes or is aborted
//   data_valid     - qualifies rx_done: frame was good
//   frame_err      - sticky stop/parity error, cleared by accepted rx_start
//   rx_data        - last good byte
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after data).
module uart_rx_datapath
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic                 rx_start,
    output logic                 start_detected,
    output logic                 rx_done,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic [DATA_BITS-1:0] rx_data
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] HALF_M1  = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_M1  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic w_rx_s;
    logic w_fall;
    logic w_frame_good;

    rx_state_t            r_state;
    logic [BAUD_W-1:0]    r_baud;
    logic [BIT_W-1:0]     r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_start_det;
    logic                 r_rx_done;
    logic                 r_data_valid;
    logic                 r_frame_err;
    logic [DATA_BITS-1:0] r_rx_data;

`ifdef UART_RX_PARITY_EN
    logic r_par;
    logic r_good;
    assign w_frame_good = r_good & w_rx_s;
`else
    assign w_frame_good = w_rx_s;
`endif

    rx_sync_edge u_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_rx    (rx_in),
        .o_rx_s  (w_rx_s),
        .o_fall  (w_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= RX_IDLE;
            r_baud       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_start_det  <= 1'b0;
            r_rx_done    <= 1'b0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_rx_data    <= '0;
`ifdef UART_RX_PARITY_EN
            r_par        <= 1'b0;
            r_good       <= 1'b0;
`endif
        end else begin
            // Pulses default low; the transition that enters DONE raises
            // rx_done/data_valid so they are high exactly in the DONE cycle.
            r_start_det  <= 1'b0;
            r_rx_done    <= 1'b0;
            r_data_valid <= 1'b0;

            case (r_state)
                RX_IDLE: begin
                    if (w_fall) begin
                        r_start_det <= 1'b1;
                        r_state     <= RX_ARMED;
                    end
                end

                RX_ARMED: begin
                    // rx_start wins over a line that has just gone high again.
                    if (rx_start) begin
                        r_frame_err <= 1'b0;
                        r_baud      <= '0;
                        r_state     <= RX_START_CHK;
                    end else if (w_rx_s) begin
                        r_state <= RX_IDLE;
                    end
                end

                RX_START_CHK: begin
                    if (r_baud == HALF_M1) begin
                        if (!w_rx_s) begin
                            r_baud  <= '0;
                            r_bit   <= '0;
                            r_state <= RX_DATA;
`ifdef UART_RX_PARITY_EN
                            r_par   <= 1'b0;
                            r_good  <= 1'b1;
`endif
                        end else begin
                            r_rx_done <= 1'b1;
                            r_state   <= RX_DONE;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end

                RX_DATA: begin
                    if (r_baud == FULL_M1) begin
                        r_baud  <= '0;
                        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
                        r_par   <= r_par ^ w_rx_s;
`endif
                        if (r_bit == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= RX_PARITY;
`else
                            r_state <= RX_STOP;
`endif
                        end else begin
                            r_bit <= r_bit + BIT_W'(1);
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (r_baud == FULL_M1) begin
                        r_baud <= '0;
                        if (w_rx_s != (r_par ^ PARITY_ODD)) begin
                            r_good      <= 1'b0;
                            r_frame_err <= 1'b1;
                        end
                        r_state <= RX_STOP;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
`endif

                RX_STOP: begin
                    if (r_baud == FULL_M1) begin
                        r_baud       <= '0;
                        r_rx_done    <= 1'b1;
                        r_data_valid <= w_frame_good;
                        // rx_data is loaded alongside rx_done so the byte is
                        // already present while data_valid is high.
                        if (w_frame_good) begin
                            r_rx_data <= r_shift;
                        end
                        if (!w_rx_s) begin
                            r_frame_err <= 1'b1;
                        end
                        r_state <= RX_DONE;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end

                RX_DONE: begin
                    r_state <= RX_IDLE;
                end

                default: begin
                    r_state <= RX_IDLE;
                end
            endcase
        end
    end

    assign start_detected = r_start_det;
    assign rx_done        = r_rx_done;
    assign data_valid     = r_data_valid;
    assign frame_err      = r_frame_err;
    assign rx_data        = r_rx_data;

endmodule
